// File: rtl/det_mon_pkg.sv
// Shared state encodings and default sizing for the detector burst monitor.
package det_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WINDOW = 2'b01,
        ALERT  = 2'b10
    } state_t;

    localparam int DEF_WINDOW_LEN = 16;
    localparam int DEF_CNT_W      = 4;
    localparam int TIMER_W        = $clog2(DEF_WINDOW_LEN);

endpackage

// File: rtl/det_burst_monitor_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Latency: count updates on the edge after inc; holds at all-ones. No backpressure.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/det_burst_monitor.sv
// Counts detector pulses in a window opened by the first pulse; holds alert until ack.
// Latency: alert rises the edge after the threshold-th pulse. No backpressure; pulses in ALERT are ignored.
// DET_MON_TOTAL_CNT_EN enables the saturating lifetime pulse counter on total_count.
module det_burst_monitor
    import det_mon_pkg::*;
#(
    parameter int WINDOW_LEN = DEF_WINDOW_LEN,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             detector,
    input  logic [CNT_W-1:0] threshold,
    input  logic             ack,
    input  logic             clear,
    output logic             alert,
    output logic [CNT_W-1:0] win_count,
    output logic             busy,
    output logic [CNT_W-1:0] total_count
);

    localparam int TW = $clog2(WINDOW_LEN);
    localparam logic [TW-1:0] LAST = TW'(WINDOW_LEN - 1);

    state_t           state, state_nxt;
    logic [TW-1:0]    timer, timer_nxt;
    logic [CNT_W-1:0] eff_thr;
    logic [CNT_W-1:0] new_count;
    logic             win_inc, win_clr;

    assign eff_thr   = (threshold == '0) ? CNT_W'(1) : threshold;
    // Count the current pulse (saturated) before comparing against the threshold.
    assign new_count = (detector && (win_count != '1)) ? win_count + 1'b1 : win_count;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
            alert <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            alert <= (state_nxt == ALERT);
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        win_inc   = 1'b0;
        win_clr   = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
            timer_nxt = '0;
            win_clr   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (detector) begin
                        win_inc   = 1'b1;
                        timer_nxt = TW'(1);
                        state_nxt = (eff_thr == CNT_W'(1)) ? ALERT : WINDOW;
                    end
                end
                WINDOW: begin
                    win_inc   = detector;
                    timer_nxt = timer + 1'b1;
                    if (new_count >= eff_thr) begin
                        state_nxt = ALERT;
                        timer_nxt = '0;
                    end else if (timer == LAST) begin
                        state_nxt = IDLE;
                        timer_nxt = '0;
                        win_clr   = 1'b1;
                    end
                end
                ALERT: begin
                    // ack wins over a coincident pulse: no new window opens here.
                    if (ack) begin
                        state_nxt = IDLE;
                        win_clr   = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                    win_clr   = 1'b1;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_win_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (win_clr),
        .inc   (win_inc),
        .count (win_count)
    );

`ifdef DET_MON_TOTAL_CNT_EN
    logic total_clr;
    assign total_clr = clear || !(state inside {IDLE, WINDOW, ALERT});

    sat_counter #(.W(CNT_W)) u_total_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (total_clr),
        .inc   (detector),
        .count (total_count)
    );
`else
    assign total_count = '0;
`endif

endmodule

// File: tb/tb_det_burst_monitor.sv
// Directed bench for det_burst_monitor (WINDOW_LEN=16, CNT_W=4, threshold=3).
module tb_det_burst_monitor;

    logic       clk;
    logic       rst;
    logic       detector;
    logic [3:0] threshold;
    logic       ack;
    logic       clear;
    logic       alert;
    logic [3:0] win_count;
    logic       busy;
    logic [3:0] total_count;

    int checks = 0;
    int errors = 0;
    int npulse = 0;

    det_burst_monitor #(.WINDOW_LEN(16), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .detector    (detector),
        .threshold   (threshold),
        .ack         (ack),
        .clear       (clear),
        .alert       (alert),
        .win_count   (win_count),
        .busy        (busy),
        .total_count (total_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Lifetime pulses sampled since the last rst/clear, saturated at 15.
    function automatic logic [31:0] etot();
`ifdef DET_MON_TOTAL_CNT_EN
        return (npulse > 15) ? 32'd15 : 32'(npulse);
`else
        return 32'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic d, input logic a);
        detector = d;
        ack      = a;
        tick();
        if (d && !rst && !clear) npulse++;
        detector = 1'b0;
        ack      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; detector = 1'b0; ack = 1'b0; clear = 1'b0; threshold = 4'd3;
        tick(); tick();
        chk("reset_alert", alert, 0);
        chk("reset_wc", win_count, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;

        // 1: reset mid-traffic
        step(1, 0); step(1, 0);
        chk("t1_wc_pre", win_count, 2);
        chk("t1_busy_pre", busy, 1);
        chk("t1_total_pre", total_count, etot());
        rst = 1'b1; detector = 1'b1;
        tick(); tick();
        rst = 1'b0; detector = 1'b0; npulse = 0;
        chk("t1_alert", alert, 0);
        chk("t1_wc", win_count, 0);
        chk("t1_busy", busy, 0);
        chk("t1_total", total_count, 0);

        // 2: pulses at window cycles 0,5,9, then ack
        step(1, 0); idle(4); step(1, 0); idle(3);
        chk("t2_alert_pre", alert, 0);
        chk("t2_wc_pre", win_count, 2);
        step(1, 0);
        chk("t2_alert", alert, 1);
        chk("t2_wc", win_count, 3);
        step(0, 0); step(1, 0);
        chk("t2_wc_frozen", win_count, 3);
        chk("t2_alert_held", alert, 1);
        step(0, 0);
        step(0, 1);
        chk("t2_ack_alert", alert, 0);
        chk("t2_ack_busy", busy, 0);
        chk("t2_ack_wc", win_count, 0);
        chk("t2_total", total_count, etot());

        // 3: pulses at cycles 0 and 15 expire without alert
        step(1, 0); idle(14);
        chk("t3_busy_last", busy, 1);
        chk("t3_wc_last", win_count, 1);
        step(1, 0);
        chk("t3_busy_end", busy, 0);
        chk("t3_wc_end", win_count, 0);
        chk("t3_alert_end", alert, 0);

        // 3b: third pulse on the last window cycle still alerts
        step(1, 0); idle(13); step(1, 0);
        chk("t3b_wc14", win_count, 2);
        step(1, 0);
        chk("t3b_alert", alert, 1);
        chk("t3b_wc", win_count, 3);
        step(0, 1);
        chk("t3b_ack_busy", busy, 0);

        // lowering threshold mid-window alerts without a pulse
        step(1, 0); step(1, 0);
        threshold = 4'd2;
        step(0, 0);
        chk("thr_low_alert", alert, 1);
        chk("thr_low_wc", win_count, 2);
        threshold = 4'd3;
        step(0, 1);

        // 4: threshold 0 behaves as 1
        threshold = 4'd0;
        step(1, 0);
        chk("t4_alert", alert, 1);
        chk("t4_wc", win_count, 1);
        step(0, 1);
        chk("t4_ack_busy", busy, 0);
        threshold = 4'd3;

        // 5: clear in WINDOW, then pulse+ack in ALERT
        step(1, 0); step(1, 0);
        chk("t5_wc_pre", win_count, 2);
        clear = 1'b1; detector = 1'b1;
        tick();
        clear = 1'b0; detector = 1'b0; npulse = 0;
        chk("t5_clr_busy", busy, 0);
        chk("t5_clr_wc", win_count, 0);
        chk("t5_clr_alert", alert, 0);
        chk("t5_clr_total", total_count, 0);
        step(1, 0); step(1, 0); step(1, 0);
        chk("t5_alert", alert, 1);
        step(1, 1);
        chk("t5_pa_busy", busy, 0);
        chk("t5_pa_alert", alert, 0);
        chk("t5_pa_wc", win_count, 0);
        chk("t5_pa_total", total_count, etot());
        step(0, 0);
        chk("t5_no_window", busy, 0);

        // 6: 20 back-to-back pulses, acking each alert
        for (int i = 0; i < 20; i++) step(1'b1, alert);
        chk("t6_total_sat", total_count, etot());
        step(0, 1);
        chk("t6_total_hold", total_count, etot());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
